// File: rtl/serial_transmitter.sv
// serial_transmitter: UART-style 8N1 transmit engine with a one-byte holding register.
// Optional: define SERIAL_TX_PARITY_EN to add an even-parity bit before the stop bit.
module serial_transmitter #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       ready,
    input  logic [1:0] baud_sel,
    output logic       dout,
    output logic       busy
);
    localparam int DIV0 = (CLK_FREQ + 9600 / 2) / 9600;
    localparam int DIV1 = (CLK_FREQ + 19200 / 2) / 19200;
    localparam int DIV2 = (CLK_FREQ + 38400 / 2) / 38400;
    localparam int DIV3 = (CLK_FREQ + 115200 / 2) / 115200;
    localparam int CW   = $clog2(DIV0 + 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic [7:0]    hold_byte;
    logic [7:0]    shift_byte;
    logic          hold_full;
    logic [1:0]    baud_lat;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_last;
    logic [2:0]    bit_idx;
    logic          bit_end;
    logic          load;

    always_comb begin
        case (baud_lat)
            2'd0:    cnt_last = CW'(DIV0 - 1);
            2'd1:    cnt_last = CW'(DIV1 - 1);
            2'd2:    cnt_last = CW'(DIV2 - 1);
            default: cnt_last = CW'(DIV3 - 1);
        endcase
    end

    assign bit_end = (cnt == cnt_last);
    assign ready   = ~hold_full;
    // A held byte starts a frame from IDLE, or directly after the last stop-bit clock.
    assign load    = hold_full && ((state == IDLE) || (state == STOP && bit_end));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dout       <= 1'b1;
            busy       <= 1'b0;
            hold_full  <= 1'b0;
            hold_byte  <= '0;
            shift_byte <= '0;
            baud_lat   <= '0;
            cnt        <= '0;
            bit_idx    <= '0;
        end else begin
            if (data_valid && !hold_full) begin
                hold_byte <= data_in;
                hold_full <= 1'b1;
            end

            cnt <= bit_end ? '0 : cnt + 1'b1;

            case (state)
                IDLE: cnt <= '0;
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        dout    <= shift_byte[0];
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                            state <= PARITY;
                            dout  <= ^shift_byte;
`else
                            state <= STOP;
                            dout  <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            dout    <= shift_byte[bit_idx + 3'd1];
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        dout  <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Overrides the per-state updates above when a frame begins.
            if (load) begin
                shift_byte <= hold_byte;
                baud_lat   <= baud_sel;
                hold_full  <= 1'b0;
                state      <= START;
                dout       <= 1'b0;
                busy       <= 1'b1;
                cnt        <= '0;
            end
        end
    end
endmodule

// File: tb/tb_serial_transmitter.sv
// tb_serial_transmitter: table-driven and randomized checks of serial_transmitter
// against a per-clock line model built from frame rules.
module tb_serial_transmitter;
    localparam int CLK_FREQ = 1_000_000;
    localparam int LIMIT    = 5000;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] data_in = '0;
    logic       data_valid = 1'b0;
    logic [1:0] baud_sel = 2'b00;
    logic       ready, dout, busy;

    int n_cmp = 0;
    int n_bad = 0;

    serial_transmitter #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .ready(ready), .baud_sel(baud_sel), .dout(dout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int div_of(input logic [1:0] s);
        int b;
        case (s)
            2'd0:    b = 9600;
            2'd1:    b = 19200;
            2'd2:    b = 38400;
            default: b = 115200;
        endcase
        return (CLK_FREQ + b / 2) / b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line model: one queued expected dout value per clock; a pending byte
    // becomes a frame when the line has no more queued bits.
    bit         exp_q[$];
    bit         pend = 1'b0;
    logic [7:0] pend_byte;

    always @(posedge clk) begin
        bit         old_p, e_d, e_b;
        int         d;
        logic [10:0] fr;
        if (!rst_n) begin
            exp_q.delete();
            pend = 1'b0;
            e_d  = 1'b1;
            e_b  = 1'b0;
        end else begin
            old_p = pend;
            if (pend && exp_q.size() == 0) begin
                d  = div_of(baud_sel);
                fr = {1'b1, ^pend_byte, pend_byte, 1'b0};
                for (int i = 0; i < FB; i++) begin
                    bit v;
                    v = (FB == 10 && i == 9) ? 1'b1 : fr[i];
                    repeat (d) exp_q.push_back(v);
                end
                pend = 1'b0;
            end
            if (exp_q.size() > 0) begin
                e_d = exp_q.pop_front();
                e_b = 1'b1;
            end else begin
                e_d = 1'b1;
                e_b = 1'b0;
            end
            if (data_valid && !old_p) begin
                pend      = 1'b1;
                pend_byte = data_in;
            end
        end
        #1;
        check("dout", dout, e_d);
        check("busy", busy, e_b);
        check("ready", ready, !pend);
    end

    task automatic send(input logic [7:0] b, input bit early);
        int t = 0;
        @(negedge clk);
        data_in = b;
        if (early) data_valid = 1'b1;
        while (!ready && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait_bound", t < LIMIT, 1);
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((busy || !ready) && t < 4 * LIMIT) begin
            @(negedge clk);
            t++;
        end
        check("idle_wait_bound", t < 4 * LIMIT, 1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] bsel;
        logic [1:0] mid_sel;
        logic [9:0] exp_frame;   // line bits, index 0 = start bit, 8N1 layout
        logic       exp_par;
    } vec_t;

    vec_t tab[7];

    initial begin
        logic [10:0] got;
        int          d;

        tab[0] = '{8'h63, 2'b00, 2'b00, 10'h2C6, 1'b0};
        tab[1] = '{8'h8E, 2'b01, 2'b01, 10'h31C, 1'b0};
        tab[2] = '{8'hA5, 2'b11, 2'b00, 10'h34A, 1'b0};
        tab[3] = '{8'h00, 2'b10, 2'b11, 10'h200, 1'b0};
        tab[4] = '{8'hFF, 2'b11, 2'b01, 10'h3FE, 1'b0};
        tab[5] = '{8'h01, 2'b11, 2'b11, 10'h202, 1'b1};
        tab[6] = '{8'h80, 2'b10, 2'b00, 10'h300, 1'b1};

        #2 rst_n = 1'b0;
        #1;
        check("reset_dout", dout, 1);
        check("reset_busy", busy, 0);
        check("reset_ready", ready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            wait_idle();
            baud_sel = tab[k].bsel;
            d = div_of(tab[k].bsel);
            send(tab[k].data, 1'b0);
            repeat (d / 2 + 1) @(negedge clk);
            for (int i = 0; i < FB; i++) begin
                got[i] = dout;
                if (i == 3) baud_sel = tab[k].mid_sel;
                if (i < FB - 1) repeat (d) @(negedge clk);
            end
`ifdef SERIAL_TX_PARITY_EN
            check("frame", {got[10], got[8:0]}, tab[k].exp_frame);
            check("parity", got[9], tab[k].exp_par);
`else
            check("frame", got[9:0], tab[k].exp_frame);
`endif
        end

        // Back-to-back: the third byte is offered while ready is low and held.
        wait_idle();
        baud_sel = 2'b00;
        send(8'h63, 1'b0);
        send(8'h8E, 1'b1);
        send(8'h5A, 1'b1);

        // Asynchronous reset during data bit 3.
        wait_idle();
        baud_sel = 2'b11;
        d = div_of(2'b11);
        send(8'hC3, 1'b0);
        repeat (4 * d + d / 2) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dout", dout, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h3C, 1'b0);

        for (int r = 0; r < 30; r++) begin
            logic [7:0] b;
            b = 8'($urandom);
            baud_sel = 2'($urandom_range(1, 3));
            send(b, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 40)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) baud_sel = 2'($urandom_range(0, 3));
        end

        wait_idle();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
